alu_result_capture: RTL

//  Downstream stage of the 4-bit ALU datapath (add/sub/logic units). Captures each ALU result
//  (Y, CarryOUT, overflow) with its opCode and derives Z/N/C/V flags. Queues results in a small

---
 rtl/alu_pkg.sv | 33 +++
 rtl/result_fifo.sv | 62 ++++++
 rtl/alu_result_capture.sv | 84 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result capture stage: opcodes, flag layout and entry packing.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_SUB = 2'b10,
    OP_OR  = 2'b11
  } aluOp_e;

  localparam int OP_W   = 2;
  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic int entryWidth(input int width);
    return width + OP_W + FLAG_W;
  endfunction

  function automatic logic [FLAG_W-1:0] packFlags(input logic z, input logic n,
                                                  input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides and an occupancy count.
// Head data is read combinationally and forced to zero while empty.
module result_fifo #(
  parameter int  DATA_W = 10,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] memReg [DEPTH];
  logic [PTR_W-1:0]  wrPtrReg;
  logic [PTR_W-1:0]  rdPtrReg;
  logic [CNT_W-1:0]  countReg;
  logic              push;
  logic              pop;

  // Ready depends only on registered occupancy, so a full FIFO never accepts even when popping.
  assign inReady  = (countReg != CNT_W'(DEPTH));
  assign outValid = (countReg != '0);
  assign push     = inValid && inReady;
  assign pop      = outReady && outValid;
  assign count    = countReg;
  assign outData  = outValid ? memReg[rdPtrReg] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      memReg[wrPtrReg] <= inData;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow of PTR_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (push) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      if (push && !pop) begin
        countReg <= countReg + CNT_W'(1);
      end else if (pop && !push) begin
        countReg <= countReg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_result_capture.sv
// Captures ALU results with derived Z/N/C/V flags into a small FIFO and
// tracks a sticky overflow flag plus a saturating overflow counter.
module alu_result_capture
  import alu_pkg::*;
#(
  parameter int  WIDTH   = 4,
  parameter int  DEPTH   = 4,
  parameter int  OVCNT_W = 8,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opCode,
  input  logic [WIDTH-1:0]   Y,
  input  logic               CarryOUT,
  input  logic               overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [OP_W-1:0]    out_opCode,
  output logic [FLAG_W-1:0]  out_flags,
  output logic [CNT_W-1:0]   count,
  input  logic               clear_sticky,
  output logic               sticky_overflow,
  output logic [OVCNT_W-1:0] ov_count
);

  localparam int ENTRY_W = entryWidth(WIDTH);

  logic [FLAG_W-1:0]  inFlags;
  logic [ENTRY_W-1:0] inEntry;
  logic [ENTRY_W-1:0] headEntry;
  logic               accepted;
  logic               stickyReg;
  logic [OVCNT_W-1:0] ovCountReg;

  assign inFlags  = packFlags(Y == '0, Y[WIDTH-1], CarryOUT, overflow);
  assign inEntry  = {Y, opCode, inFlags};
  assign accepted = in_valid && in_ready;

  result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   (inEntry),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (headEntry),
    .count    (count)
  );

  // Head entry is already zero when empty, so the fields need no extra masking.
  assign out_result = headEntry[ENTRY_W-1 -: WIDTH];
  assign out_opCode = headEntry[FLAG_W +: OP_W];
  assign out_flags  = headEntry[FLAG_W-1:0];

  // A V=1 capture in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      stickyReg  <= 1'b0;
      ovCountReg <= '0;
    end else if (accepted && overflow) begin
      stickyReg <= 1'b1;
      if (clear_sticky) begin
        ovCountReg <= OVCNT_W'(1);
      end else if (ovCountReg != '1) begin
        ovCountReg <= ovCountReg + OVCNT_W'(1);
      end
    end else if (clear_sticky) begin
      stickyReg  <= 1'b0;
      ovCountReg <= '0;
    end
  end

  assign sticky_overflow = stickyReg;
  assign ov_count        = ovCountReg;

endmodule
